// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with valid/ready handshakes.
// A 2-entry skid buffer keeps in_ready a registered function of the stage state only.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_inst,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            ill;
    logic [31:0]     inst;
  } entry_t;

  entry_t          dec;
  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  logic            out_valid_q, out_valid_d;
  logic            skid_full_q, skid_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            accept, drain;

  // Sign fill first, then the format-specific low bits overwrite it.
  always_comb begin
    dec      = '0;
    dec.inst = inst;
    dec.fmt  = FMT_ILL;
    unique case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec.fmt       = FMT_I;
        dec.imm       = {XLEN{inst[31]}};
        dec.imm[11:0] = inst[31:20];
      end
      7'b0100011: begin
        dec.fmt       = FMT_S;
        dec.imm       = {XLEN{inst[31]}};
        dec.imm[11:0] = {inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        dec.fmt       = FMT_B;
        dec.imm       = {XLEN{inst[31]}};
        dec.imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt       = FMT_U;
        dec.imm       = {XLEN{inst[31]}};
        dec.imm[31:0] = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt       = FMT_J;
        dec.imm       = {XLEN{inst[31]}};
        dec.imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b0110011: dec.fmt = FMT_R;
      default:    dec.fmt = FMT_ILL;
    endcase
    dec.ill = (dec.fmt == FMT_ILL);
  end

  assign accept = in_valid && !skid_full_q;
  assign drain  = out_valid_q && out_ready;

  // A full skid entry always has priority into the output register to keep FIFO order.
  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    cnt_d       = cnt_q;
    if (skid_full_q) begin
      if (drain) begin
        out_d       = skid_q;
        skid_full_d = 1'b0;
      end
    end else if (!out_valid_q || drain) begin
      out_valid_d = accept;
      if (accept) out_d = dec;
    end else if (accept) begin
      skid_d      = dec;
      skid_full_d = 1'b1;
    end
    if (accept && dec.ill && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready    = !skid_full_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.ill;
  assign out_inst    = out_q.inst;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share
// one stimulus stream and are checked every cycle against a 2-deep FIFO reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] inst = '0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_inst32;
  logic [2:0]  out_fmt32;
  logic [7:0]  cnt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_inst64;
  logic [2:0]  out_fmt64;
  logic [7:0]  cnt64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .inst(inst),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32), .out_inst(out_inst32), .illegal_cnt(cnt32));

  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .inst(inst),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_inst(out_inst64), .illegal_cnt(cnt64));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference decode using signed arithmetic shifts instead of bit concatenation.
  function automatic void ref_dec(input logic [31:0] w, output logic [63:0] imm,
                                  output logic [2:0] fmt);
    longint x;
    x = longint'($signed(w));
    imm = 64'd0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: begin fmt = 3'd1; imm = x >>> 20; end
      7'h23: begin fmt = 3'd2; imm = ((x >>> 25) <<< 5) | longint'(w[11:7]); end
      7'h63: begin
        fmt = 3'd3;
        imm = ((x >>> 31) <<< 12) + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
              + longint'(w[11:8]) * 2;
      end
      7'h37, 7'h17: begin fmt = 3'd4; imm = x & 64'hFFFF_FFFF_FFFF_F000; end
      7'h6F: begin
        fmt = 3'd5;
        imm = ((x >>> 31) <<< 20) + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
              + longint'(w[30:21]) * 2;
      end
      7'h33:   fmt = 3'd0;
      default: fmt = 3'd7;
    endcase
  endfunction

  logic [31:0] mq[$];
  int          mcnt = 0;
  bit          m_pop, m_push;
  logic [63:0] t_imm;
  logic [2:0]  t_fmt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_push = in_valid && (mq.size() < 2);
      if (m_push) begin
        ref_dec(inst, t_imm, t_fmt);
        if (t_fmt == 3'd7 && mcnt < 255) mcnt++;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(inst);
    end
  end

  logic [63:0] e_imm;
  logic [2:0]  e_fmt;

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready32", in_ready32, mq.size() < 2);
      chk("in_ready64", in_ready64, mq.size() < 2);
      chk("out_valid32", out_valid32, mq.size() > 0);
      chk("out_valid64", out_valid64, mq.size() > 0);
      chk("illegal_cnt32", cnt32, mcnt);
      chk("illegal_cnt64", cnt64, mcnt);
      if (mq.size() > 0) begin
        ref_dec(mq[0], e_imm, e_fmt);
        chk("out_inst32", out_inst32, mq[0]);
        chk("out_inst64", out_inst64, mq[0]);
        chk("out_fmt32", out_fmt32, e_fmt);
        chk("out_fmt64", out_fmt64, e_fmt);
        chk("out_illegal32", out_illegal32, e_fmt == 3'd7);
        chk("out_illegal64", out_illegal64, e_fmt == 3'd7);
        chk("out_imm32", out_imm32, e_imm[31:0]);
        chk("out_imm64", out_imm64, e_imm);
      end
    end
  end

  logic [31:0] dir_w[4]   = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h800002B7};
  logic [63:0] dir_imm[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_000C,
                              64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_8000_0000};
  logic [2:0]  dir_fmt[4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [6:0]  ops[10]    = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                              7'h33, 7'h7F};
  logic [31:0] bp_w[4]    = '{32'h00500093, 32'h00A12223, 32'h123452B7, 32'h0000007F};

  initial begin
    logic [63:0] p_imm;
    logic [2:0]  p_fmt;
    logic [31:0] r;
    int          idx;
    bit          acc;

    // Pin the reference model on hand-decoded words.
    for (int i = 0; i < 4; i++) begin
      ref_dec(dir_w[i], p_imm, p_fmt);
      chk("model_imm", p_imm, dir_imm[i]);
      chk("model_fmt", p_fmt, dir_fmt[i]);
    end

    #3;
    chk("rst_out_valid", out_valid32, 1'b0);
    chk("rst_in_ready", in_ready32, 1'b1);
    chk("rst_out_imm", out_imm64, 64'd0);
    chk("rst_out_fmt", out_fmt32, 3'd0);
    chk("rst_out_illegal", out_illegal32, 1'b0);
    chk("rst_out_inst", out_inst32, 32'd0);
    chk("rst_illegal_cnt", cnt32, 8'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed words, one per cycle, one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      in_valid = 1'b1;
      inst = dir_w[i];
      @(posedge clk); #1;
      chk("dir_valid", out_valid32, 1'b1);
      chk("dir_imm64", out_imm64, dir_imm[i]);
      chk("dir_imm32", out_imm32, dir_imm[i][31:0]);
      chk("dir_fmt", out_fmt64, dir_fmt[i]);
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);

    // Back-pressure: 3 cycles of out_ready=0 while streaming 4 words.
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      @(negedge clk); #1;
      out_ready = (cyc >= 3);
      in_valid  = 1'b1;
      inst      = bp_w[idx];
      if (cyc == 2) begin
        chk("bp_in_ready_low", in_ready32, 1'b0);
        chk("bp_head_held", out_inst32, bp_w[0]);
      end
      acc = in_ready32;
      @(posedge clk);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 4);
    @(negedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Randomised traffic with random back-pressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk); #1;
      r = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      inst = {r[31:7], ops[$urandom_range(0, 9)]};
      if ($urandom_range(0, 7) == 0) inst[6:0] = r[6:0];
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Saturation of the illegal counter.
    #1;
    in_valid = 1'b1;
    inst = 32'h0000007F;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("cnt_saturated32", cnt32, 8'd255);
    chk("cnt_saturated64", cnt64, 8'd255);
    repeat (2) @(negedge clk);

    // Reset while two words are held.
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = 32'h00100093;
    @(negedge clk); #1;
    inst = 32'h00200113;
    @(negedge clk); #1;
    in_valid = 1'b0;
    chk("held_in_ready", in_ready32, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid32, 1'b0);
    chk("midrst_out_valid64", out_valid64, 1'b0);
    chk("midrst_in_ready", in_ready32, 1'b1);
    chk("midrst_cnt", cnt32, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
